// File: rtl/csel_pipe_adder.sv
// rtl/csel_pipe_adder.sv - pipelined carry-select adder/subtractor, one BLOCK-bit slice per stage
module csel_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NBLK = WIDTH / BLOCK;

    if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_param_check
        $error("csel_pipe_adder: WIDTH must be a positive multiple of BLOCK");
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;

    // The whole pipe advances together unless a finished result is waiting on downstream.
    always_comb begin
        en    = out_ready | ~out_valid;
        b_eff = sub ? ~b : b;
    end

    assign in_ready = en;

    // Stage s resolves block s; each stage keeps only the operand bits still to be added.
    for (genvar s = 0; s < NBLK; s++) begin : g_stg
        localparam int LO  = s * BLOCK;
        localparam int REM = WIDTH - LO - BLOCK;

        logic [BLOCK-1:0]    x;
        logic [BLOCK-1:0]    y;
        logic                c_in;
        logic                v_in;
        logic [BLOCK:0]      sum0;
        logic [BLOCK:0]      sum1;
        logic [BLOCK:0]      blk;
        logic                v_d, v_q;
        logic                c_d, c_q;
        logic [LO+BLOCK-1:0] s_d, s_q;

        if (s == 0) begin : g_src
            // First stage takes operands straight from the ports.
            always_comb begin
                x    = a[BLOCK-1:0];
                y    = b_eff[BLOCK-1:0];
                c_in = cin;
                v_in = in_valid;
                s_d  = blk[BLOCK-1:0];
            end
        end else begin : g_src
            // Later stages take the next slice and the carry from the previous stage.
            always_comb begin
                x    = g_stg[s-1].g_rem.a_q[BLOCK-1:0];
                y    = g_stg[s-1].g_rem.b_q[BLOCK-1:0];
                c_in = g_stg[s-1].c_q;
                v_in = g_stg[s-1].v_q;
                s_d  = {blk[BLOCK-1:0], g_stg[s-1].s_q};
            end
        end

        // Both carry hypotheses are formed in parallel; the registered carry picks one.
        always_comb begin
            sum0 = {1'b0, x} + {1'b0, y};
            sum1 = {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, 1'b1};
            blk  = c_in ? sum1 : sum0;
            c_d  = blk[BLOCK];
            v_d  = v_in;
        end

        // Stage valid, accumulated low sum bits and outgoing carry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_d;
                c_q <= c_d;
                s_q <= s_d;
            end
        end

        if (REM > 0) begin : g_rem
            logic [REM-1:0] a_d, a_q;
            logic [REM-1:0] b_d, b_q;

            if (s == 0) begin : g_from_port
                // Drop the slice consumed here; keep the upper operand bits.
                always_comb begin
                    a_d = a[WIDTH-1:BLOCK];
                    b_d = b_eff[WIDTH-1:BLOCK];
                end
            end else begin : g_from_stage
                // Drop the slice consumed here; keep the upper operand bits.
                always_comb begin
                    a_d = g_stg[s-1].g_rem.a_q[REM+BLOCK-1:BLOCK];
                    b_d = g_stg[s-1].g_rem.b_q[REM+BLOCK-1:BLOCK];
                end
            end

            // Operand bits still waiting for later stages.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (s == NBLK - 1) begin : g_last
            logic ovf_d, ovf_q;

            // Carry into the MSB is recovered from the MSB operand and sum bits.
            always_comb begin
                ovf_d = x[BLOCK-1] ^ y[BLOCK-1] ^ blk[BLOCK-1] ^ blk[BLOCK];
            end

            // Signed overflow flag travels with the final stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    // Outputs come straight from the last stage registers.
    always_comb begin
        out_valid = g_stg[NBLK-1].v_q;
        sum       = g_stg[NBLK-1].s_q;
        cout      = g_stg[NBLK-1].c_q;
        ovf       = g_stg[NBLK-1].g_last.ovf_q;
    end
endmodule

// File: tb/tb_csel_pipe_adder.sv
// tb/tb_csel_pipe_adder.sv - scoreboard bench for csel_pipe_adder
module tb_csel_pipe_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    logic        v8 = 1'b0;
    logic        r8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        c8i = 1'b0;
    logic        s8i = 1'b0;
    logic        ov8;
    logic        or8 = 1'b1;
    logic [7:0]  sum8;
    logic        co8;
    logic        of8;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t q8[$];
    exp_t me;
    exp_t me8;

    logic        held = 1'b0;
    logic [31:0] hsum;
    logic        hcout;
    logic        hovf;

    csel_pipe_adder #(.WIDTH(32), .BLOCK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    csel_pipe_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
        .a(a8), .b(b8), .cin(c8i), .sub(s8i), .out_valid(ov8),
        .out_ready(or8), .sum(sum8), .cout(co8), .ovf(of8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic send(input logic [31:0] ta, input logic [31:0] tb, input logic tc, input logic ts,
                        input logic [31:0] es, input logic ec, input logic eo, input bit chk_lat);
        int g = 0;
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        #1;
        while (!in_ready && g < 100) begin
            @(negedge clk); #1;
            g++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end else begin
            exp_q.push_back('{s: es, c: ec, o: eo, acc: cyc + 1, lat: chk_lat});
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input logic ts,
                         input logic [7:0] es, input logic ec, input logic eo);
        a8 = ta; b8 = tb; c8i = tc; s8i = ts; v8 = 1'b1;
        #1;
        chk("in_ready8", r8, 1);
        q8.push_back('{s: {24'b0, es}, c: ec, o: eo, acc: cyc + 1, lat: 1'b1});
        @(posedge clk);
        @(negedge clk);
        v8 = 1'b0;
    endtask

    // Monitor for the 32-bit instance: hold stability, stall handshake and in-order results.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_out_valid", out_valid, 1);
                chk("hold_sum", sum, hsum);
                chk("hold_cout", cout, hcout);
                chk("hold_ovf", ovf, hovf);
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got sum 0x%0h, expected no beat", sum);
                end else begin
                    me = exp_q.pop_front();
                    chk("sum", sum, me.s);
                    chk("cout", cout, me.c);
                    chk("ovf", ovf, me.o);
                    if (me.lat) chk("latency", cyc - me.acc + 1, 4);
                end
            end
            held  = out_valid && !out_ready;
            hsum  = sum;
            hcout = cout;
            hovf  = ovf;
        end
    end

    // Monitor for the single-block instance.
    always @(negedge clk) begin
        if (rst_n && ov8 && or8) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_beat8: got sum 0x%0h, expected no beat", sum8);
            end else begin
                me8 = q8.pop_front();
                chk("sum8", sum8, me8.s);
                chk("cout8", co8, me8.c);
                chk("ovf8", of8, me8.o);
                chk("latency8", cyc - me8.acc + 1, 1);
            end
        end
    end

    initial begin
        int g;
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_sum", sum, 0);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_cout", cout, 0);
        chk("post_rst_ovf", ovf, 0);
        @(negedge clk);

        send(32'h0000_0001, 32'h0000_0002, 0, 0, 32'h0000_0003, 0, 0, 1);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1, 0, 32'h0000_0000, 1, 0, 1);
        send(32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 32'h8000_0000, 0, 1, 1);
        send(32'h0000_0005, 32'h0000_0007, 1, 1, 32'hFFFF_FFFE, 0, 0, 1);
        send(32'h0000_0007, 32'h0000_0005, 1, 1, 32'h0000_0002, 1, 0, 1);
        send(32'h0000_0007, 32'h0000_0005, 0, 1, 32'h0000_0001, 1, 0, 1);
        send(32'h8000_0000, 32'h0000_0001, 1, 1, 32'h7FFF_FFFF, 1, 1, 1);
        send(32'h0000_00FF, 32'h0000_0001, 0, 0, 32'h0000_0100, 0, 0, 1);
        send(32'h00FF_FF00, 32'h0000_0100, 0, 0, 32'h0100_0000, 0, 0, 1);
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin @(negedge clk); g++; end

        fork
            begin
                for (int i = 0; i < 8; i++) send(i, i * 3, 0, 0, i * 4, 0, 0, 0);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin @(negedge clk); g++; end

        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        send(32'd100, 32'd1, 0, 0, 32'd101, 0, 0, 0);
        send(32'd200, 32'd2, 0, 0, 32'd202, 0, 0, 0);
        send(32'd300, 32'd3, 0, 0, 32'd303, 0, 0, 0);
        g = 0;
        while (!out_valid && g < 20) begin @(negedge clk); g++; end
        chk("midflight_valid_before_rst", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_out_valid", out_valid, 0);
        chk("rst_async_sum", sum, 0);
        exp_q.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_stale_out_valid", out_valid, 0);
        send(32'd10, 32'd20, 0, 0, 32'd30, 0, 0, 1);

        send8(8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
        send8(8'h7F, 8'h01, 0, 0, 8'h80, 0, 1);
        send8(8'h03, 8'h05, 1, 1, 8'hFE, 0, 0);
        send8(8'h80, 8'h01, 1, 1, 8'h7F, 1, 1);

        g = 0;
        while ((exp_q.size() != 0 || q8.size() != 0) && g < 50) begin @(negedge clk); g++; end
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("scoreboard8_empty", q8.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
